// File: rtl/sha_block_ctrl.sv
// Ping-pong block buffer and start/done sequencer between the Message Packer
// word stream and the SHA-256 compression core.
module sha_block_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int WORDS_PER_BLK = 16,
  parameter int BLK_CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] mp_data_in,
  input  logic                  mp_dv_in,
  input  logic [BLK_CNT_W-1:0]  cfg_blocks_in,
  output logic                  core_start_out,
  output logic                  core_first_out,
  input  logic [$clog2(WORDS_PER_BLK)-1:0] core_rd_idx_in,
  output logic [DATA_WIDTH-1:0] core_word_out,
  input  logic                  core_done_in,
  output logic                  msg_done_out,
  output logic                  busy_out,
  output logic                  err_overflow_out
);

  localparam int IDX_W = $clog2(WORDS_PER_BLK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLK - 1);

  typedef enum logic [1:0] {IDLE, START, RUN, FINISH} state_t;

  state_t                 state;
  logic [DATA_WIDTH-1:0]  bank [2*WORDS_PER_BLK];
  logic [1:0]             full;
  logic [1:0]             full_next;
  logic                   wr_bank;
  logic                   rd_bank;
  logic [IDX_W-1:0]       wr_cnt;
  logic [BLK_CNT_W-1:0]   blk_rx;
  logic [BLK_CNT_W-1:0]   blk_done;
  logic [BLK_CNT_W-1:0]   blk_total;
  logic [BLK_CNT_W-1:0]   total_eff;
  logic                   done_run;
  logic                   bank_free;
  logic                   accept;
  logic                   last_word;
  logic                   last_blk;

  // A bank released by the core this very cycle is already writable.
  assign done_run  = (state == RUN) && core_done_in;
  assign bank_free = !full[wr_bank] || (done_run && (rd_bank == wr_bank));
  assign total_eff = busy_out ? blk_total
                   : ((cfg_blocks_in == '0) ? BLK_CNT_W'(1) : cfg_blocks_in);
  assign accept    = mp_dv_in && bank_free && (blk_rx < total_eff);
  assign last_word = (wr_cnt == LAST_IDX);
  assign last_blk  = ({1'b0, blk_done} + 1'b1) == {1'b0, blk_total};

  always_comb begin
    full_next = full;
    if (done_run)
      full_next[rd_bank] = 1'b0;
    if (accept && last_word)
      full_next[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (accept)
      bank[{wr_bank, wr_cnt}] <= mp_data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      core_word_out <= '0;
    else
      core_word_out <= bank[{rd_bank, core_rd_idx_in}];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      full             <= '0;
      wr_bank          <= 1'b0;
      rd_bank          <= 1'b0;
      wr_cnt           <= '0;
      blk_rx           <= '0;
      blk_done         <= '0;
      blk_total        <= '0;
      core_start_out   <= 1'b0;
      core_first_out   <= 1'b0;
      msg_done_out     <= 1'b0;
      busy_out         <= 1'b0;
      err_overflow_out <= 1'b0;
    end else begin
      core_start_out <= 1'b0;
      core_first_out <= 1'b0;
      msg_done_out   <= 1'b0;
      full           <= full_next;

      if (mp_dv_in && !accept)
        err_overflow_out <= 1'b1;
      if (accept) begin
        if (!busy_out) begin
          busy_out  <= 1'b1;
          blk_total <= total_eff;
        end
        if (last_word) begin
          wr_cnt  <= '0;
          wr_bank <= ~wr_bank;
          blk_rx  <= blk_rx + 1'b1;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (full[rd_bank])
            state <= START;
        end
        START: begin
          core_start_out <= 1'b1;
          core_first_out <= (blk_done == '0);
          state          <= RUN;
        end
        RUN: begin
          if (core_done_in) begin
            rd_bank  <= ~rd_bank;
            blk_done <= blk_done + 1'b1;
            state    <= last_blk ? FINISH : IDLE;
          end
        end
        FINISH: begin
          // Message closes here; counters rewind for the next one.
          msg_done_out <= 1'b1;
          busy_out     <= 1'b0;
          blk_rx       <= '0;
          blk_done     <= '0;
          wr_cnt       <= '0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_block_ctrl.sv
// Scoreboard bench for sha_block_ctrl: stimulus queues expected start, word
// and msg_done events by cycle; a negedge monitor pops and compares them.
module tb_sha_block_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mp_data_in = '0;
  logic        mp_dv_in = 1'b0;
  logic [7:0]  cfg_blocks_in = '0;
  logic        core_start_out;
  logic        core_first_out;
  logic [3:0]  core_rd_idx_in = '0;
  logic [31:0] core_word_out;
  logic        core_done_in = 1'b0;
  logic        msg_done_out;
  logic        busy_out;
  logic        err_overflow_out;

  sha_block_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mp_data_in       (mp_data_in),
    .mp_dv_in         (mp_dv_in),
    .cfg_blocks_in    (cfg_blocks_in),
    .core_start_out   (core_start_out),
    .core_first_out   (core_first_out),
    .core_rd_idx_in   (core_rd_idx_in),
    .core_word_out    (core_word_out),
    .core_done_in     (core_done_in),
    .msg_done_out     (msg_done_out),
    .busy_out         (busy_out),
    .err_overflow_out (err_overflow_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  typedef struct { int cyc; logic first; } start_t;
  typedef struct { int cyc; logic [31:0] val; } word_t;
  start_t sq[$];
  word_t  wq[$];
  int     mq[$];
  start_t s_pop;
  word_t  w_pop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name, input int act, input int exp);
    compared++;
    mismatched++;
    $display("FAIL %s: actual %0d required %0d", name, act, exp);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (core_start_out) begin
        if (sq.size() == 0) fail_evt("unexpected_start_cycle", cyc, -1);
        else begin
          s_pop = sq.pop_front();
          check("start_cycle", cyc, s_pop.cyc);
          check("start_first", {31'b0, core_first_out}, {31'b0, s_pop.first});
        end
      end else if (core_first_out) begin
        fail_evt("first_without_start_cycle", cyc, -1);
      end
      while (sq.size() > 0 && sq[0].cyc < cyc) begin
        s_pop = sq.pop_front();
        fail_evt("missed_start_cycle", cyc, s_pop.cyc);
      end
      if (msg_done_out) begin
        if (mq.size() == 0) fail_evt("unexpected_msg_done_cycle", cyc, -1);
        else check("msg_done_cycle", cyc, mq.pop_front());
      end
      while (mq.size() > 0 && mq[0] < cyc)
        fail_evt("missed_msg_done_cycle", cyc, mq.pop_front());
      while (wq.size() > 0 && wq[0].cyc < cyc) begin
        w_pop = wq.pop_front();
        fail_evt("missed_word_cycle", cyc, w_pop.cyc);
      end
      if (wq.size() > 0 && wq[0].cyc == cyc) begin
        w_pop = wq.pop_front();
        check("core_word", core_word_out, w_pop.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic send_word(input logic [31:0] w);
    mp_data_in = w;
    mp_dv_in   = 1'b1;
    tick();
    mp_dv_in   = 1'b0;
    mp_data_in = '0;
  endtask

  task automatic send_seq(input logic [31:0] base, input int first_k, input int n);
    for (int k = first_k; k < first_k + n; k++) send_word(base + 32'(k));
  endtask

  task automatic read_word(input logic [3:0] idx, input logic [31:0] exp);
    core_rd_idx_in = idx;
    wq.push_back('{cyc + 1, exp});
    tick();
  endtask

  task automatic pulse_done();
    core_done_in = 1'b1;
    tick();
    core_done_in = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    tick();
    check({tag, "_rst_start"}, {31'b0, core_start_out}, 32'd0);
    check({tag, "_rst_first"}, {31'b0, core_first_out}, 32'd0);
    check({tag, "_rst_word"}, core_word_out, 32'd0);
    check({tag, "_rst_msg_done"}, {31'b0, msg_done_out}, 32'd0);
    check({tag, "_rst_busy"}, {31'b0, busy_out}, 32'd0);
    check({tag, "_rst_err"}, {31'b0, err_overflow_out}, 32'd0);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int m;
    logic [31:0] abc [16];

    do_reset("init");

    // 1: 'abc' single block
    for (int k = 0; k < 16; k++) abc[k] = 32'h0;
    abc[0]  = 32'h6162_6380;
    abc[15] = 32'h0000_0018;
    cfg_blocks_in = 8'd1;
    c0 = cyc;
    sq.push_back('{c0 + 18, 1'b1});
    for (int k = 0; k < 16; k++) send_word(abc[k]);
    check("t1_busy", {31'b0, busy_out}, 32'd1);
    wait_until(c0 + 18);
    read_word(4'd0, 32'h6162_6380);
    read_word(4'd15, 32'h0000_0018);
    m = cyc;
    mq.push_back(m + 2);
    pulse_done();
    repeat (3) tick();
    check("t1_busy_end", {31'b0, busy_out}, 32'd0);

    // 2: two blocks back-to-back, done 80 clocks after each start
    cfg_blocks_in = 8'd2;
    c0 = cyc;
    sq.push_back('{c0 + 18, 1'b1});
    send_seq(32'h2000_0000, 0, 32);
    wait_until(c0 + 18 + 80);
    m = cyc;
    sq.push_back('{m + 3, 1'b0});
    pulse_done();
    wait_until(m + 3);
    read_word(4'd0, 32'h2000_0010);
    read_word(4'd7, 32'h2000_0017);
    wait_until(m + 3 + 80);
    m = cyc;
    mq.push_back(m + 2);
    pulse_done();
    repeat (4) tick();
    check("t2_busy_end", {31'b0, busy_out}, 32'd0);
    check("t2_err", {31'b0, err_overflow_out}, 32'd0);

    // 3: overflow with core_done withheld
    do_reset("t3");
    cfg_blocks_in = 8'd3;
    c0 = cyc;
    sq.push_back('{c0 + 18, 1'b1});
    send_seq(32'h3000_0000, 0, 48);
    check("t3_err", {31'b0, err_overflow_out}, 32'd1);
    check("t3_busy", {31'b0, busy_out}, 32'd1);
    read_word(4'd0, 32'h3000_0000);
    read_word(4'd5, 32'h3000_0005);
    read_word(4'd15, 32'h3000_000F);
    repeat (3) tick();
    check("t3_err_sticky", {31'b0, err_overflow_out}, 32'd1);

    // 4: freed-bank race, word 33 lands in the bank released the same cycle
    do_reset("t4");
    cfg_blocks_in = 8'd3;
    c0 = cyc;
    sq.push_back('{c0 + 18, 1'b1});
    send_seq(32'h4000_0000, 0, 32);
    m = cyc;
    sq.push_back('{m + 3, 1'b0});
    core_done_in = 1'b1;
    mp_data_in   = 32'h4000_0020;
    mp_dv_in     = 1'b1;
    tick();
    core_done_in = 1'b0;
    mp_dv_in     = 1'b0;
    check("t4_err_race", {31'b0, err_overflow_out}, 32'd0);
    send_seq(32'h4000_0000, 33, 15);
    check("t4_err_fill", {31'b0, err_overflow_out}, 32'd0);
    read_word(4'd0, 32'h4000_0010);
    read_word(4'd3, 32'h4000_0013);
    m = cyc;
    sq.push_back('{m + 3, 1'b0});
    pulse_done();
    wait_until(m + 3);
    read_word(4'd0, 32'h4000_0020);
    read_word(4'd15, 32'h4000_002F);
    m = cyc;
    mq.push_back(m + 2);
    pulse_done();
    repeat (3) tick();
    check("t4_busy_end", {31'b0, busy_out}, 32'd0);
    check("t4_err_end", {31'b0, err_overflow_out}, 32'd0);

    // 5: reset in RUN, then a fresh message
    do_reset("t5a");
    cfg_blocks_in = 8'd1;
    c0 = cyc;
    sq.push_back('{c0 + 18, 1'b1});
    send_seq(32'h5000_0000, 0, 16);
    wait_until(c0 + 20);
    do_reset("t5b");
    c0 = cyc;
    sq.push_back('{c0 + 18, 1'b1});
    send_seq(32'h5100_0000, 0, 16);
    wait_until(c0 + 18);
    read_word(4'd2, 32'h5100_0002);
    m = cyc;
    mq.push_back(m + 2);
    pulse_done();
    repeat (3) tick();
    check("t5_busy_end", {31'b0, busy_out}, 32'd0);

    // 6: stray done in IDLE, cfg=0 treated as one block
    do_reset("t6");
    pulse_done();
    repeat (3) tick();
    check("t6_busy_idle", {31'b0, busy_out}, 32'd0);
    cfg_blocks_in = 8'd0;
    c0 = cyc;
    sq.push_back('{c0 + 18, 1'b1});
    send_seq(32'h6000_0000, 0, 16);
    wait_until(c0 + 18);
    read_word(4'd9, 32'h6000_0009);
    m = cyc;
    mq.push_back(m + 2);
    pulse_done();
    repeat (3) tick();
    check("t6_busy_end", {31'b0, busy_out}, 32'd0);
    pulse_done();
    repeat (4) tick();
    check("t6_busy_after_stray", {31'b0, busy_out}, 32'd0);
    check("t6_err", {31'b0, err_overflow_out}, 32'd0);

    while (sq.size() > 0) begin
      s_pop = sq.pop_front();
      fail_evt("pending_start_cycle", cyc, s_pop.cyc);
    end
    while (mq.size() > 0) fail_evt("pending_msg_done_cycle", cyc, mq.pop_front());
    while (wq.size() > 0) begin
      w_pop = wq.pop_front();
      fail_evt("pending_word_cycle", cyc, w_pop.cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
